// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte-wide valid/ready into a small FIFO, serialized at BAUDRATE. Start bit leaves on the edge after a pop.
// Backpressure: in_ready drops while the FIFO is full; frames are sent back-to-back while bytes remain queued.

module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    // Ready comes from the registered count only; a same-edge pop does not free a slot early.
    assign wr_rdy = (count != CW'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx #(
    parameter int CLKRATE  = 1_790_000,
    parameter int BAUDRATE = 9600,
    parameter int DEPTH    = 4,
    parameter int STOPBITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       empty
);
    localparam int DIVISOR   = (CLKRATE + BAUDRATE / 2) / BAUDRATE;
    localparam int STOP_CLKS = STOPBITS * DIVISOR;
    localparam int CW        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          fifo_empty;
    logic          pop;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (in_data),
        .rd_en  (pop),
        .rd_dat (head),
        .empty  (fifo_empty)
    );

    // A pop happens either from idle or on the last stop clock, which chains frames without a gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            case (state)
                IDLE:    pop = 1'b1;
                STOP:    pop = (div_cnt == STOP_LAST);
                default: pop = 1'b0;
            endcase
        end
    end

    assign busy  = (state != IDLE) || !fifo_empty;
    assign empty = fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift   <= head;
                        state   <= START;
                        tx      <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                START: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (div_cnt == STOP_LAST) begin
                        div_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
